lsu_stage: RTL and testbench

- Load/store stage directly downstream of the execute unit in the NPC core.
- Consumes the execute result (`EXU_data`) as either an effective address or a pass-through value, and runs multi-cycle memory transactions over a valid/ready request/response bus.
- Produces the write-back value with byte/half lane extraction and sign/zero extension.
- Decouples the core from variable memory latency with input and output handshakes.

---
 rtl/lsu_stage.sv | 184 ++++++++++++++++++
 tb/tb_lsu_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// lsu_stage: load/store stage that sits directly after the execute unit.
//
// An accepted op either passes EXU_data straight through, or uses it as an
// effective address for one memory transaction on a valid/ready request bus.
// Load results are lane-extracted and extended before being handed to
// write-back. At most one op is in flight at a time.
//
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   in_valid / in_ready  handshake with the execute stage
//   EXU_data             result or effective address
//   store_data           rs2 value for stores
//   LSU_mode             {mem_op, store, funct3}
//   out_valid / out_ready handshake toward write-back
//   LSU_data, misalign   write-back value and misaligned-access flag
//   mem_req_*            memory request channel (addr/wen/wdata/wmask)
//   mem_resp_valid       read data or write acknowledge, always accepted
//   mem_rdata            read data word
module lsu_stage #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] EXU_data,
  input  logic [DATAWIDTH-1:0] store_data,
  input  logic [4:0]           LSU_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] LSU_data,
  output logic                 misalign,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [DATAWIDTH-1:0] mem_addr,
  output logic                 mem_wen,
  output logic [DATAWIDTH-1:0] mem_wdata,
  output logic [3:0]           mem_wmask,
  input  logic                 mem_resp_valid,
  input  logic [DATAWIDTH-1:0] mem_rdata
);

  // The lane logic below is written for a 32-bit word only.
  if (DATAWIDTH != 32) begin : g_bad_width
    $error("lsu_stage supports DATAWIDTH = 32 only");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t state, next_state;

  logic        accept;
  logic        in_is_byte;
  logic        in_is_half;
  logic        in_misaligned;
  logic [31:0] in_wdata;
  logic [3:0]  in_wmask;

  logic [1:0]  addr_lo_q;
  logic [3:0]  mode_q;
  logic [31:0] mem_addr_q;
  logic        mem_wen_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wmask_q;
  logic [31:0] lsu_data_q;
  logic        misalign_q;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;

  assign accept = in_valid && in_ready;

  // Decode the incoming op: access size from funct3[1:0] (illegal encodings
  // fall into the word case), alignment, and the lane-shifted store fields.
  always_comb begin
    in_is_byte    = (LSU_mode[1:0] == 2'b00);
    in_is_half    = (LSU_mode[1:0] == 2'b01);
    in_misaligned = 1'b0;
    in_wdata      = store_data;
    in_wmask      = 4'b1111;
    if (in_is_byte) begin
      in_wdata = {4{store_data[7:0]}};
      in_wmask = 4'b0001 << EXU_data[1:0];
    end else if (in_is_half) begin
      in_wdata      = {2{store_data[15:0]}};
      in_wmask      = 4'b0011 << EXU_data[1:0];
      in_misaligned = EXU_data[0];
    end else begin
      in_misaligned = (EXU_data[1:0] != 2'b00);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic. Pass-through and misaligned ops skip the bus entirely.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) begin
        if (!LSU_mode[4] || in_misaligned) next_state = RESP;
        else                               next_state = REQ;
      end
      REQ:  if (mem_req_ready)  next_state = WAIT;
      WAIT: if (mem_resp_valid) next_state = RESP;
      RESP: if (out_ready)      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs depend on state only, so reset drops them at once.
  always_comb begin
    in_ready      = (state == IDLE);
    mem_req_valid = (state == REQ);
    out_valid     = (state == RESP);
  end

  // Load lane extraction; mode_q[2] selects zero extension.
  assign load_byte = mem_rdata[{addr_lo_q, 3'b000} +: 8];
  assign load_half = mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];

  always_comb begin
    case (mode_q[2:0])
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_value = {24'b0, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b101:  load_value = {16'b0, load_half};
      default: load_value = mem_rdata;
    endcase
  end

  // Datapath registers: request fields are captured at accept and held
  // unchanged through REQ; the result is captured when the op completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_lo_q   <= 2'b00;
      mode_q      <= 4'b0;
      mem_addr_q  <= 32'b0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= 32'b0;
      mem_wmask_q <= 4'b0;
      lsu_data_q  <= 32'b0;
      misalign_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          addr_lo_q <= EXU_data[1:0];
          mode_q    <= LSU_mode[3:0];
          if (!LSU_mode[4]) begin
            lsu_data_q <= EXU_data;
            misalign_q <= 1'b0;
          end else if (in_misaligned) begin
            lsu_data_q <= 32'b0;
            misalign_q <= 1'b1;
          end else begin
            mem_addr_q  <= {EXU_data[31:2], 2'b00};
            mem_wen_q   <= LSU_mode[3];
            mem_wdata_q <= LSU_mode[3] ? in_wdata : 32'b0;
            mem_wmask_q <= LSU_mode[3] ? in_wmask : 4'b0;
          end
        end
        WAIT: if (mem_resp_valid) begin
          lsu_data_q <= mode_q[3] ? 32'b0 : load_value;
        end
        RESP: if (out_ready) begin
          misalign_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign LSU_data  = lsu_data_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: randomized self-checking bench for lsu_stage.
//
// Each op is driven cycle by cycle from one process. A behavioural model
// (plain arithmetic on addresses, byte counts and lane offsets) supplies the
// expected request fields and write-back value; every cycle the outputs are
// compared against what the current phase of the op requires.
module tb_lsu_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] EXU_data;
  logic [31:0] store_data;
  logic [4:0]  LSU_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] LSU_data;
  logic        misalign;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  lsu_stage #(.DATAWIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .EXU_data       (EXU_data),
    .store_data     (store_data),
    .LSU_mode       (LSU_mode),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .LSU_data       (LSU_data),
    .misalign       (misalign),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends even if the sequencing goes wrong.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  // Number of bytes touched by an access; unlisted funct3 values act as words.
  function automatic int accessBytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] loadResult(input logic [31:0] addr,
                                             input logic [31:0] rdata,
                                             input logic [2:0]  f3);
    int          n;
    logic [31:0] v;
    logic [31:0] range;
    n = accessBytes(f3);
    if (n == 4) return rdata;
    range = (n == 1) ? 32'h100 : 32'h10000;
    v = (rdata >> (32'd8 * (addr % 32'd4))) % range;
    if (!f3[2] && v >= range / 32'd2) v = v - range;
    return v;
  endfunction

  function automatic logic [3:0] storeMask(input logic [31:0] addr, input int n);
    int m;
    m = ((1 << n) - 1) << (addr % 32'd4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] storeData(input logic [31:0] sd, input int n);
    if (n == 1) return (sd % 32'h100) * 32'h01010101;
    if (n == 2) return (sd % 32'h10000) * 32'h00010001;
    return sd;
  endfunction

  // Runs one op from accept to write-back handshake. Called and returns at a
  // falling edge with the DUT idle. Delays give the number of stall cycles
  // before request ready, response valid and output ready respectively.
  task automatic applyStimulus(input logic [31:0] exu, input logic [31:0] sd,
                               input logic [4:0] mode, input int req_delay,
                               input int resp_delay, input int out_delay,
                               input logic [31:0] rdata);
    int          n;
    logic        exp_mis;
    logic        issue;
    logic [31:0] exp_data;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;

    n         = accessBytes(mode[2:0]);
    exp_mis   = mode[4] && ((exu % 32'd4) % n != 0);
    issue     = mode[4] && !exp_mis;
    exp_addr  = exu - (exu % 32'd4);
    exp_wdata = mode[3] ? storeData(sd, n) : 32'h0;
    exp_wmask = mode[3] ? storeMask(exu, n) : 4'h0;
    if (!mode[4])                exp_data = exu;
    else if (exp_mis || mode[3]) exp_data = 32'h0;
    else                         exp_data = loadResult(exu, rdata, mode[2:0]);

    checkBit("idle in_ready", in_ready, 1'b1);
    in_valid   = 1'b1;
    EXU_data   = exu;
    store_data = sd;
    LSU_mode   = mode;
    @(negedge clk);
    in_valid   = 1'b0;
    EXU_data   = $urandom;
    store_data = $urandom;
    LSU_mode   = 5'($urandom);

    if (issue) begin
      for (int c = 0; c <= req_delay; c++) begin
        checkBit("req valid", mem_req_valid, 1'b1);
        checkOutput("req addr", mem_addr, exp_addr);
        checkBit("req wen", mem_wen, mode[3]);
        checkOutput("req wdata", mem_wdata, exp_wdata);
        checkOutput("req wmask", {28'b0, mem_wmask}, {28'b0, exp_wmask});
        checkBit("req out_valid", out_valid, 1'b0);
        checkBit("req in_ready", in_ready, 1'b0);
        mem_req_ready  = (c == req_delay);
        mem_resp_valid = 1'($urandom_range(0, 1));
        mem_rdata      = $urandom;
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      for (int c = 0; c <= resp_delay; c++) begin
        checkBit("wait req valid", mem_req_valid, 1'b0);
        checkBit("wait out_valid", out_valid, 1'b0);
        checkBit("wait in_ready", in_ready, 1'b0);
        mem_resp_valid = (c == resp_delay);
        mem_rdata      = (c == resp_delay) ? rdata : $urandom;
        @(negedge clk);
      end
      mem_resp_valid = 1'b0;
      mem_rdata      = $urandom;
    end

    for (int c = 0; c <= out_delay; c++) begin
      checkBit("resp out_valid", out_valid, 1'b1);
      checkOutput("resp data", LSU_data, exp_data);
      checkBit("resp misalign", misalign, exp_mis);
      checkBit("resp in_ready", in_ready, 1'b0);
      checkBit("resp req valid", mem_req_valid, 1'b0);
      out_ready = (c == out_delay);
      @(negedge clk);
    end
    out_ready = 1'b0;
    checkBit("done out_valid", out_valid, 1'b0);
    checkBit("done in_ready", in_ready, 1'b1);
    checkBit("done misalign", misalign, 1'b0);
  endtask

  initial begin
    logic [4:0]  mode;
    logic [31:0] addr;

    rst_n          = 1'b0;
    in_valid       = 1'b0;
    EXU_data       = 32'h0;
    store_data     = 32'h0;
    LSU_mode       = 5'h0;
    out_ready      = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;

    // Hand-computed values pinning the model.
    checkOutput("model lb", loadResult(32'h80000003, 32'h80FF0000, 3'b000), 32'hFFFFFF80);
    checkOutput("model lbu", loadResult(32'h80000003, 32'h80FF0000, 3'b100), 32'h00000080);
    checkOutput("model lhu", loadResult(32'h80000002, 32'h12348765, 3'b101), 32'h00001234);
    checkOutput("model lh", loadResult(32'h80000000, 32'h12348765, 3'b001), 32'hFFFF8765);
    checkOutput("model sh wdata", storeData(32'hAAAABEEF, 2), 32'hBEEFBEEF);
    checkOutput("model sh wmask", {28'b0, storeMask(32'h80000012, 2)}, 32'hC);
    checkOutput("model sb wmask", {28'b0, storeMask(32'h80000011, 1)}, 32'h2);

    repeat (2) @(negedge clk);
    checkBit("reset in_ready", in_ready, 1'b1);
    checkBit("reset out_valid", out_valid, 1'b0);
    checkBit("reset req valid", mem_req_valid, 1'b0);
    checkBit("reset misalign", misalign, 1'b0);
    checkBit("reset wen", mem_wen, 1'b0);
    checkOutput("reset data", LSU_data, 32'h0);
    checkOutput("reset addr", mem_addr, 32'h0);
    checkOutput("reset wdata", mem_wdata, 32'h0);
    checkOutput("reset wmask", {28'b0, mem_wmask}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed ops");
    applyStimulus(32'h00001234, 32'h0, 5'b00000, 0, 0, 0, 32'h0);
    applyStimulus(32'h80000003, 32'h0, 5'b10000, 0, 0, 0, 32'h80FF0000);
    applyStimulus(32'h80000003, 32'h0, 5'b10100, 0, 0, 0, 32'h80FF0000);
    applyStimulus(32'h80000012, 32'hAAAABEEF, 5'b11001, 3, 1, 0, 32'h0);
    applyStimulus(32'h80000002, 32'h0, 5'b10010, 0, 0, 0, 32'h0);
    applyStimulus(32'h80000002, 32'h0, 5'b10101, 0, 0, 5, 32'h12348765);
    applyStimulus(32'h80000004, 32'h0, 5'b10111, 1, 2, 1, 32'hCAFEF00D);

    $display("[TB] random ops");
    for (int i = 0; i < 200; i++) begin
      mode = 5'($urandom);
      if ($urandom_range(0, 4) != 0) mode[4] = 1'b1;
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      applyStimulus(addr, $urandom, mode, $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("[TB] reset during wait");
    in_valid = 1'b1;
    EXU_data = 32'h80000040;
    LSU_mode = 5'b10010;
    @(negedge clk);
    in_valid      = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    checkBit("wait before reset req valid", mem_req_valid, 1'b0);
    checkBit("wait before reset in_ready", in_ready, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checkBit("mid reset req valid", mem_req_valid, 1'b0);
    checkBit("mid reset out_valid", out_valid, 1'b0);
    checkBit("mid reset in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hDEADBEEF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    checkBit("stale resp out_valid", out_valid, 1'b0);
    checkBit("stale resp in_ready", in_ready, 1'b1);
    @(negedge clk);
    checkBit("stale resp out_valid later", out_valid, 1'b0);
    applyStimulus(32'h80000044, 32'h0, 5'b10010, 0, 0, 0, 32'h13572468);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
